// File: rtl/seq_alu.sv
// Handshaked ALU: one-cycle add/sub/shift/logic, iterative shift-add mul and restoring div.
// Latency: 1 edge for single-cycle ops, WIDTH edges after accept for mul/div.
// Backpressure: result held in DONE until out_ready; in_ready is high only in IDLE.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flag
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_XNOR = 4'h9;
    localparam logic [3:0] OP_NAND = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             is_mul;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    logic             accept;
    logic             is_iter_op;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic             shift_oob;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic [3:0]       sc_flag;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [3:0]       iter_flag;

    assign in_ready   = (state == S_IDLE);
    assign out_valid  = (state == S_DONE);
    assign accept     = in_valid && in_ready;
    assign is_iter_op = (sel == OP_MUL) || (sel == OP_DIV);

    assign add_sum   = {1'b0, a} + {1'b0, b};
    assign sub_diff  = {1'b0, a} - {1'b0, b};
    assign shift_oob = (b >= WIDTH'(WIDTH));

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        case (sel)
            OP_ADD: begin
                sc_res = add_sum[WIDTH-1:0];
                sc_c   = add_sum[WIDTH];
            end
            OP_SUB: begin
                sc_res = sub_diff[WIDTH-1:0];
                sc_c   = sub_diff[WIDTH];
            end
            OP_SHL:  sc_res = shift_oob ? '0 : (a << b);
            OP_SHR:  sc_res = shift_oob ? '0 : (a >> b);
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_XNOR: sc_res = ~(a ^ b);
            OP_NAND: sc_res = ~(a & b);
            OP_NOR:  sc_res = ~(a | b);
            default: sc_res = '0;
        endcase
    end

    assign sc_flag = {1'b0, 1'b0, sc_c, (sc_res == '0)};

    // Mul: {hi,lo} starts as {0,b}; add a into hi when lo[0] is set, then shift the pair right.
    assign mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, op_a} : '0);

    // Div: {hi,lo} starts as {0,a}; shift dividend bits into the remainder and subtract when it fits.
    // A zero divisor always "fits", which naturally yields all-ones quotient and remainder a.
    assign div_sh  = {work_hi, work_lo[WIDTH-1]};
    assign div_ge  = (div_sh >= {1'b0, op_b});
    assign div_sub = div_sh - {1'b0, op_b};

    always_comb begin
        if (is_mul) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end else begin
            step_hi = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], div_ge};
        end
    end

    always_comb begin
        if (is_mul) begin
            iter_flag = {1'b0, (step_hi != '0), 1'b0, (step_lo == '0)};
        end else begin
            iter_flag = {(op_b == '0), 1'b0, 1'b0, (step_lo == '0)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            is_mul    <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            work_hi   <= '0;
            work_lo   <= '0;
            result    <= '0;
            result_hi <= '0;
            flag      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_a   <= a;
                        op_b   <= b;
                        is_mul <= (sel == OP_MUL);
                        if (is_iter_op) begin
                            state   <= S_BUSY;
                            cnt     <= CW'(WIDTH - 1);
                            work_hi <= '0;
                            work_lo <= (sel == OP_MUL) ? b : a;
                        end else begin
                            state     <= S_DONE;
                            result    <= sc_res;
                            result_hi <= '0;
                            flag      <= sc_flag;
                        end
                    end
                end
                S_BUSY: begin
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                    cnt     <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state     <= S_DONE;
                        result    <= step_lo;
                        result_hi <= step_hi;
                        flag      <= iter_flag;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8): vector table plus back-pressure and mid-operation reset sequences.
module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic [3:0]   flag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [3:0]   sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [W-1:0] rh;
        logic [3:0]   f;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flag      (flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string n, input logic [3:0] s, input logic [W-1:0] va,
                           input logic [W-1:0] vb, input logic [W-1:0] r, input logic [W-1:0] rh,
                           input logic [3:0] f, input int lat);
        vec_t v;
        v.name = n; v.sel = s; v.a = va; v.b = vb;
        v.r = r; v.rh = rh; v.f = f; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Called #1 after a rising edge; returns #1 after the accept edge with inputs scrambled.
    task automatic start_op(input string n, input logic [3:0] s, input logic [W-1:0] va,
                            input logic [W-1:0] vb);
        in_valid = 1'b1;
        sel      = s;
        a        = va;
        b        = vb;
        chk({n, ".in_ready_before"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sel      = ~s;
        a        = ~va;
        b        = vb + 8'h5A;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic take(input string n);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({n, ".out_valid_after_take"}, 32'(out_valid), 32'd0);
        chk({n, ".in_ready_after_take"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int cyc;

        add_vec("add_carry",  4'h0, 8'hAB, 8'h84, 8'h2F, 8'h00, 4'b0010, 0);
        add_vec("sub_borrow", 4'h1, 8'h04, 8'h2B, 8'hD9, 8'h00, 4'b0010, 0);
        add_vec("sub_equal",  4'h1, 8'h2B, 8'h2B, 8'h00, 8'h00, 4'b0001, 0);
        add_vec("mul_ovf",    4'h2, 8'hAB, 8'h84, 8'h2C, 8'h58, 4'b0100, W);
        add_vec("mul_small",  4'h2, 8'h2B, 8'h04, 8'hAC, 8'h00, 4'b0000, W);
        add_vec("div_basic",  4'h3, 8'h2B, 8'h04, 8'h0A, 8'h03, 4'b0000, W);
        add_vec("div_zero_q", 4'h3, 8'h04, 8'h2B, 8'h00, 8'h04, 4'b0001, W);
        add_vec("div_by_0",   4'h3, 8'h2B, 8'h00, 8'hFF, 8'h2B, 4'b1000, W);
        add_vec("shl_4",      4'h4, 8'h2B, 8'h04, 8'hB0, 8'h00, 4'b0000, 0);
        add_vec("shr_big",    4'h5, 8'h2B, 8'h84, 8'h00, 8'h00, 4'b0001, 0);
        add_vec("shr_7",      4'h5, 8'h80, 8'h07, 8'h01, 8'h00, 4'b0000, 0);
        add_vec("shl_8",      4'h4, 8'h01, 8'h08, 8'h00, 8'h00, 4'b0001, 0);
        add_vec("and",        4'h6, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 0);
        add_vec("or",         4'h7, 8'hF0, 8'h0F, 8'hFF, 8'h00, 4'b0000, 0);
        add_vec("xor",        4'h8, 8'hAA, 8'hAA, 8'h00, 8'h00, 4'b0001, 0);
        add_vec("xnor",       4'h9, 8'hAA, 8'h55, 8'h00, 8'h00, 4'b0001, 0);
        add_vec("nand",       4'hA, 8'hFF, 8'h0F, 8'hF0, 8'h00, 4'b0000, 0);
        add_vec("nor",        4'hB, 8'h00, 8'h00, 8'hFF, 8'h00, 4'b0000, 0);
        add_vec("sel_c",      4'hC, 8'h12, 8'h34, 8'h00, 8'h00, 4'b0001, 0);
        add_vec("add_wrap",   4'h0, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b0011, 0);
        add_vec("mul_max",    4'h2, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0100, W);
        add_vec("mul_zero",   4'h2, 8'h00, 8'h05, 8'h00, 8'h00, 4'b0001, W);

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sel       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.result", 32'(result), 32'd0);
        chk("reset.result_hi", 32'(result_hi), 32'd0);
        chk("reset.flag", 32'(flag), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            start_op(vecs[i].name, vecs[i].sel, vecs[i].a, vecs[i].b);
            wait_done(cyc);
            chk({vecs[i].name, ".latency"}, 32'(cyc), 32'(vecs[i].lat));
            chk({vecs[i].name, ".result"}, 32'(result), 32'(vecs[i].r));
            chk({vecs[i].name, ".result_hi"}, 32'(result_hi), 32'(vecs[i].rh));
            chk({vecs[i].name, ".flag"}, 32'(flag), 32'(vecs[i].f));
            take(vecs[i].name);
        end

        // Back-pressure: result held, in_ready low, in_valid pulses ignored.
        start_op("bp", 4'h0, 8'h10, 8'h20);
        wait_done(cyc);
        chk("bp.latency", 32'(cyc), 32'd0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            sel      = 4'h1;
            a        = 8'(i * 7);
            b        = 8'h01;
            @(posedge clk);
            #1;
            chk("bp.out_valid_held", 32'(out_valid), 32'd1);
            chk("bp.in_ready_low", 32'(in_ready), 32'd0);
            chk("bp.result_held", 32'(result), 32'h30);
            chk("bp.flag_held", 32'(flag), 32'b0000);
        end
        in_valid = 1'b0;
        take("bp");
        chk("bp.result_after_take", 32'(result), 32'h30);

        // Reset three cycles into a multiply.
        start_op("rst_mul", 4'h2, 8'hAB, 8'h84);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mul.busy_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mul.in_ready", 32'(in_ready), 32'd1);
        chk("rst_mul.out_valid", 32'(out_valid), 32'd0);
        chk("rst_mul.result", 32'(result), 32'd0);
        chk("rst_mul.result_hi", 32'(result_hi), 32'd0);
        chk("rst_mul.flag", 32'(flag), 32'd0);
        start_op("post_rst_add", 4'h0, 8'h01, 8'h01);
        wait_done(cyc);
        chk("post_rst_add.latency", 32'(cyc), 32'd0);
        chk("post_rst_add.result", 32'(result), 32'h02);
        chk("post_rst_add.flag", 32'(flag), 32'b0000);
        take("post_rst_add");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
